// File: rtl/multicycle_sequencer.sv
// Stage controller for the multi-cycle core: PC, FETCH..WRITE FSM, req/ack memory handshakes,
// halt/resume, ack timeout and PC-alignment error. Optional perf counters under `PERF_CNT_EN`.
//
//  state   | meaning
//  IDLE    | first cycle after reset release
//  FETCH   | IMEM_REQ held until IMEM_ACK, INSTR captured on ack
//  DECODE  | RF_RD_EN pulse
//  EXECUTE | NEXT_PC / DEC_MEM_OP sampled, alignment checked
//  MEM     | DMEM_REQ held until DMEM_ACK
//  WRITE   | RF_WE pulse, PC update, halt decision
//  HALT    | parked at an instruction boundary until RESUME
//  ERROR   | terminal until reset (timeout or misaligned PC)
module multicycle_sequencer #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int              PC_ALIGN  = 2,
  parameter int              TIMEOUT   = 64,
  parameter int              CNT_W     = 32
) (
  input  logic            CLK,
  input  logic            RSTN,
  output logic            IMEM_REQ,
  output logic [XLEN-1:0] IMEM_ADDR,
  input  logic            IMEM_ACK,
  input  logic [31:0]     IMEM_RDATA,
  output logic [31:0]     INSTR,
  input  logic            DEC_MEM_OP,
  input  logic            DEC_RD_WEN,
  input  logic [XLEN-1:0] NEXT_PC,
  output logic            RF_RD_EN,
  output logic            DMEM_REQ,
  input  logic            DMEM_ACK,
  output logic            RF_WE,
  output logic [XLEN-1:0] PC,
  output logic [2:0]      STATE,
  input  logic            HALT_REQ,
  input  logic            RESUME,
  output logic            HALTED,
  output logic            ERR
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] CYCLE_CNT,
  output logic [CNT_W-1:0] INSTRET_CNT
`endif
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WRITE   = 3'd5,
    S_HALT    = 3'd6,
    S_ERROR   = 3'd7
  } state_t;

  // Down-counter loaded with TIMEOUT-1 outside the wait states; reaching 0 while still
  // waiting means TIMEOUT cycles have elapsed without an ack.
  localparam int              TMR_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD  = (TIMEOUT > 0) ? TMR_W'(TIMEOUT - 1) : '0;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~({XLEN{1'b1}} << PC_ALIGN);

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc_q, npc_q;
  logic [31:0]       instr_q;
  logic [TMR_W-1:0]  tmr;
  logic              tmr_done;
  logic              misalign;

  assign tmr_done = (TIMEOUT != 0) && (tmr == '0);
  assign misalign = |(NEXT_PC & ALIGN_MASK);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    IMEM_REQ  = 1'b0;
    DMEM_REQ  = 1'b0;
    RF_RD_EN  = 1'b0;
    RF_WE     = 1'b0;
    HALTED    = 1'b0;
    ERR       = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_FETCH;
      S_FETCH: begin
        IMEM_REQ = 1'b1;
        if (IMEM_ACK)      state_nxt = S_DECODE;
        else if (tmr_done) state_nxt = S_ERROR;
      end
      S_DECODE: begin
        RF_RD_EN  = 1'b1;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (misalign)        state_nxt = S_ERROR;
        else if (DEC_MEM_OP) state_nxt = S_MEM;
        else                 state_nxt = S_WRITE;
      end
      S_MEM: begin
        DMEM_REQ = 1'b1;
        if (DMEM_ACK)      state_nxt = S_WRITE;
        else if (tmr_done) state_nxt = S_ERROR;
      end
      S_WRITE: begin
        RF_WE     = DEC_RD_WEN;
        state_nxt = HALT_REQ ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        HALTED = 1'b1;
        if (RESUME) state_nxt = S_FETCH;
      end
      S_ERROR: ERR = 1'b1;
      default: state_nxt = S_ERROR;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      pc_q    <= RESET_VEC;
      npc_q   <= RESET_VEC;
      instr_q <= '0;
      tmr     <= '0;
    end else begin
      if (state == S_FETCH && IMEM_ACK) instr_q <= IMEM_RDATA;
      if (state == S_EXECUTE)           npc_q   <= NEXT_PC;
      if (state == S_WRITE)             pc_q    <= npc_q;
      if (state != S_FETCH && state != S_MEM) tmr <= TMR_LOAD;
      else if (tmr != '0)                     tmr <= tmr - 1'b1;
    end
  end

  assign PC        = pc_q;
  assign IMEM_ADDR = pc_q;
  assign INSTR     = instr_q;
  assign STATE     = state;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, instret_cnt;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (state != S_IDLE && state != S_HALT && state != S_ERROR) cycle_cnt <= cycle_cnt + 1'b1;
      if (state == S_WRITE) instret_cnt <= instret_cnt + 1'b1;
    end
  end

  assign CYCLE_CNT   = cycle_cnt;
  assign INSTRET_CNT = instret_cnt;
`endif

endmodule
